demux_collect16: RTL and testbench

//   Serial-to-parallel collector for the multiplier datapath: the inverse of the 16:1 bit-select path.

---
 rtl/mult_pkg.sv | 12 +
 rtl/decoder4to16.sv | 18 +
 rtl/demux_collect16.sv | 91 +++++++++
 tb/tb_demux_collect16.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and state encoding for the multiplier datapath
package mult_pkg;

    localparam int COLLECT_WIDTH = 16;
    localparam int COLLECT_SEL_W = 4;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_FULL    = 1'b1
    } collect_state_e;

endpackage

// File: rtl/decoder4to16.sv
// rtl/decoder4to16.sv - lane select plus enable to one-hot write enables
module decoder4to16 #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [WIDTH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            onehot[i] = en & (sel == SEL_W'(i));
        end
    end

endmodule

// File: rtl/demux_collect16.sv
// rtl/demux_collect16.sv - serial-to-parallel collector with valid/ready word output
module demux_collect16 import mult_pkg::*; #(
    parameter int WIDTH     = COLLECT_WIDTH,
    parameter int SEL_W     = COLLECT_SEL_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic [SEL_W-1:0] lane
);

    collect_state_e   state_q, state_d;
    logic [SEL_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [WIDTH-1:0] wr_en;
    logic             accept;
    logic             fire;

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = (state_q == ST_COLLECT) | out_ready;
    assign out_word  = word_q;

    // abort swallows the bit and any pending fire in the same cycle
    assign accept = in_valid & in_ready & ~abort;
    assign fire   = out_valid & out_ready & ~abort;

    assign lane = MSB_FIRST ? (SEL_W'(WIDTH - 1) - count_q) : count_q;

    decoder4to16 #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_decoder (
        .sel    (lane),
        .en     (accept),
        .onehot (wr_en)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        word_d  = word_q;
        if (abort) begin
            state_d = ST_COLLECT;
            count_d = '0;
            word_d  = '0;
        end else begin
            if (accept) begin
                // first bit of a word clears every other lane so nothing stale survives
                if (count_q == '0) begin
                    word_d = wr_en & {WIDTH{in_bit}};
                end else begin
                    word_d = (word_q & ~wr_en) | (wr_en & {WIDTH{in_bit}});
                end
                count_d = count_q + SEL_W'(1);
            end
            case (state_q)
                ST_COLLECT: begin
                    if (accept && (count_q == SEL_W'(WIDTH - 1))) begin
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (fire) begin
                        state_d = ST_COLLECT;
                    end
                end
                default: state_d = ST_COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_COLLECT;
            count_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_demux_collect16.sv
// tb/tb_demux_collect16.sv - directed self-checking bench for demux_collect16
module tb_demux_collect16;

    logic        clk = 1'b0;
    logic        reset, abort, in_valid, in_bit, out_ready;
    logic        in_ready, out_valid;
    logic [15:0] out_word;
    logic [3:0]  lane;

    logic        m_abort, m_in_valid, m_in_bit, m_out_ready;
    logic        m_in_ready, m_out_valid;
    logic [15:0] m_out_word;
    logic [3:0]  m_lane;

    int checks   = 0;
    int failures = 0;

    logic [15:0] words [3];

    always #5 clk = ~clk;

    demux_collect16 #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .lane      (lane)
    );

    demux_collect16 #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .reset     (reset),
        .abort     (m_abort),
        .in_valid  (m_in_valid),
        .in_bit    (m_in_bit),
        .in_ready  (m_in_ready),
        .out_valid (m_out_valid),
        .out_ready (m_out_ready),
        .out_word  (m_out_word),
        .lane      (m_lane)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; abort = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        m_abort = 1'b0; m_in_valid = 1'b0; m_in_bit = 1'b0; m_out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_word !== 16'h0) begin failures++; $display("FAIL reset_word got=%h exp=0000", out_word); end
        checks++; if (lane !== 4'd0) begin failures++; $display("FAIL reset_lane got=%0d exp=0", lane); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (m_lane !== 4'd15) begin failures++; $display("FAIL reset_msb_lane got=%0d exp=15", m_lane); end
    endtask

    task automatic test_fill_5555();
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_bit = (i % 2 == 0);
            checks++; if (lane !== 4'(i)) begin failures++; $display("FAIL fill_lane got=%0d exp=%0d", lane, i); end
            tick();
            if (i < 15) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fill_early_valid i=%0d got=%b exp=0", i, out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fill_valid got=%b exp=1", out_valid); end
        checks++; if (out_word !== 16'h5555) begin failures++; $display("FAIL fill_word got=%h exp=5555", out_word); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        checks++; if (lane !== 4'd0) begin failures++; $display("FAIL fill_lane_wrap got=%0d exp=0", lane); end
    endtask

    task automatic test_hold();
        in_valid = 1'b1; in_bit = 1'b0; out_ready = 1'b0;
        repeat (5) begin
            tick();
            checks++; if (out_word !== 16'h5555) begin failures++; $display("FAIL hold_word got=%h exp=5555", out_word); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_valid got=%b exp=1", out_valid); end
            checks++; if (lane !== 4'd0) begin failures++; $display("FAIL hold_lane got=%0d exp=0", lane); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_ready_pass got=%b exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_fire_valid got=%b exp=0", out_valid); end
        checks++; if (out_word !== 16'h5555) begin failures++; $display("FAIL hold_retain got=%h exp=5555", out_word); end
        checks++; if (lane !== 4'd0) begin failures++; $display("FAIL hold_fire_lane got=%0d exp=0", lane); end
    endtask

    task automatic test_streaming();
        int fires;
        logic [15:0] w;
        fires = 0;
        words[0] = 16'hA5C3; words[1] = 16'h0F0F; words[2] = 16'h1234;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 48; c++) begin
            w = words[c / 16];
            in_bit = w[c % 16];
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready c=%0d got=%b exp=1", c, in_ready); end
            tick();
            if ((c + 1) % 16 == 0) begin
                fires++;
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid c=%0d got=%b exp=1", c, out_valid); end
                checks++; if (out_word !== w) begin failures++; $display("FAIL stream_word c=%0d got=%h exp=%h", c, out_word, w); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_idle_valid c=%0d got=%b exp=0", c, out_valid); end
            end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_last_fire got=%b exp=0", out_valid); end
        checks++; if (fires != 3) begin failures++; $display("FAIL stream_fire_count got=%0d exp=3", fires); end
    endtask

    task automatic test_msb_first();
        m_in_valid = 1'b1; m_out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_in_bit = (i == 0);
            checks++; if (m_lane !== 4'(15 - i)) begin failures++; $display("FAIL msb_lane got=%0d exp=%0d", m_lane, 15 - i); end
            tick();
        end
        m_in_valid = 1'b0;
        checks++; if (m_out_valid !== 1'b1) begin failures++; $display("FAIL msb_valid got=%b exp=1", m_out_valid); end
        checks++; if (m_out_word !== 16'h8000) begin failures++; $display("FAIL msb_word got=%h exp=8000", m_out_word); end
    endtask

    task automatic test_abort();
        in_valid = 1'b1; in_bit = 1'b1; out_ready = 1'b0;
        repeat (7) tick();
        checks++; if (lane !== 4'd7) begin failures++; $display("FAIL abort_pre_lane got=%0d exp=7", lane); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (out_word !== 16'h0) begin failures++; $display("FAIL abort_word got=%h exp=0000", out_word); end
        checks++; if (lane !== 4'd0) begin failures++; $display("FAIL abort_lane got=%0d exp=0", lane); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", out_valid); end
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i < 15) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_early_valid i=%0d got=%b exp=0", i, out_valid); end
            end
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL abort_refill_valid got=%b exp=1", out_valid); end
        checks++; if (out_word !== 16'hFFFF) begin failures++; $display("FAIL abort_refill_word got=%h exp=ffff", out_word); end
        abort = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
        tick();
        abort = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_full_valid got=%b exp=0", out_valid); end
        checks++; if (out_word !== 16'h0) begin failures++; $display("FAIL abort_full_word got=%h exp=0000", out_word); end
    endtask

    task automatic test_reset_full();
        in_valid = 1'b1; in_bit = 1'b1; out_ready = 1'b0;
        repeat (16) tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rstfull_pre_valid got=%b exp=1", out_valid); end
        reset = 1'b1; out_ready = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstfull_valid got=%b exp=0", out_valid); end
        checks++; if (out_word !== 16'h0) begin failures++; $display("FAIL rstfull_word got=%h exp=0000", out_word); end
        checks++; if (lane !== 4'd0) begin failures++; $display("FAIL rstfull_lane got=%0d exp=0", lane); end
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstfull_in_ready got=%b exp=1", in_ready); end
    endtask

    initial begin
        test_reset();
        test_fill_5555();
        test_hold();
        test_streaming();
        test_msb_first();
        test_abort();
        test_reset_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
